// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage.
// Owns the word-indexed program counter and drives it to a combinational instruction memory.
// Each returned word is queued with its PC in a small FIFO, and decode drains that FIFO over valid/ready.
// A redirect from execute flushes the FIFO and reloads the PC.
// Optional feature macro: FETCH_HALT_EN.
//   When it is defined, fetching an all-ones word stops further fetches until a redirect or a reset.
//   When it is undefined, halted is always 0.
module fetch_stage #(
  parameter int                    PC_WIDTH    = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = {PC_WIDTH{1'b0}},
  parameter int                    QUEUE_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [PC_WIDTH-1:0]    program_counter,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   out_valid,
  output logic [INSTR_WIDTH-1:0] out_instruction,
  output logic [PC_WIDTH-1:0]    out_pc,
  input  logic                   out_ready,
  output logic                   halted
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  logic [PC_WIDTH-1:0]    pc_r;
  logic [CNT_W-1:0]       count_r;
  logic [PTR_W-1:0]       head_r;
  logic [PTR_W-1:0]       tail_r;
  logic                   halted_r;
  logic [PC_WIDTH-1:0]    pc_q_r    [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] instr_q_r [QUEUE_DEPTH];

  logic                   pop_s;
  logic                   push_s;
  logic                   halt_hit_s;
  logic                   nonempty_s;

  // Handshake decode: the full check uses the count at the start of the cycle, so a same-cycle pop never frees space.
  always_comb begin
    nonempty_s = (count_r != {CNT_W{1'b0}});
    pop_s      = nonempty_s & out_ready;
    push_s     = ~redirect_valid & ~halted_r & (count_r < DEPTH_C);
`ifdef FETCH_HALT_EN
    halt_hit_s = push_s & (instruction == {INSTR_WIDTH{1'b1}});
`else
    halt_hit_s = 1'b0;
`endif
  end

  // PC, FIFO pointers/count and halt flag; a redirect outranks both push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r     <= RESET_PC;
      count_r  <= {CNT_W{1'b0}};
      head_r   <= {PTR_W{1'b0}};
      tail_r   <= {PTR_W{1'b0}};
      halted_r <= 1'b0;
    end else if (redirect_valid) begin
      pc_r     <= redirect_pc;
      count_r  <= {CNT_W{1'b0}};
      head_r   <= {PTR_W{1'b0}};
      tail_r   <= {PTR_W{1'b0}};
      halted_r <= 1'b0;
    end else begin
      if (push_s) begin
        pc_r   <= pc_r + PC_WIDTH'(1);
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (halt_hit_s) begin
        halted_r <= 1'b1;
      end
    end
  end

  // FIFO storage: write the fetched word and its PC at the tail; no reset needed because out_* is gated by the count.
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      pc_q_r[tail_r]    <= pc_r;
      instr_q_r[tail_r] <= instruction;
    end
  end

  // Head presentation is driven from FIFO state only, and zeroes the payload when the FIFO is empty.
  always_comb begin
    out_valid       = nonempty_s;
    out_instruction = {INSTR_WIDTH{1'b0}};
    out_pc          = {PC_WIDTH{1'b0}};
    if (nonempty_s) begin
      out_instruction = instr_q_r[head_r];
      out_pc          = pc_q_r[head_r];
    end else begin
      out_instruction = {INSTR_WIDTH{1'b0}};
      out_pc          = {PC_WIDTH{1'b0}};
    end
  end

  assign program_counter = pc_r;
  assign halted          = halted_r;

endmodule
